// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read misses stall the core while a full 128-bit line is fetched from RAM.
module dcache_ctrl #(
  parameter int unsigned LINES       = 8,
  parameter int unsigned FILL_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   cpu_addr,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         stall,
  output logic [9:0]   mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_wdata,
  input  logic [127:0] mem_rdata,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = 8 - INDEX_W;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];
  logic [15:0]        hit_count_q, miss_count_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag_f;
  logic [1:0]         off;
  logic               hit;
  logic               hit_inc, miss_inc, fill_done, wr_hit;

  assign idx   = cpu_addr[INDEX_W+1:2];
  assign tag_f = cpu_addr[9:INDEX_W+2];
  assign off   = cpu_addr[1:0];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag_f);

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    stall     = 1'b0;
    cpu_rdata = 32'h0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    fill_done = 1'b0;
    wr_hit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Stores win over a simultaneous load; the load is dropped entirely.
        if (cpu_write) begin
          mem_write = 1'b1;
          wr_hit    = hit;
        end else if (cpu_read) begin
          if (hit) begin
            cpu_rdata = data_q[idx][{off, 5'b0} +: 32];
            hit_inc   = 1'b1;
          end else begin
            stall    = 1'b1;
            miss_inc = 1'b1;
            state_d  = StFill;
            cnt_d    = 4'(FILL_CYCLES - 1);
          end
        end
      end
      StFill: begin
        mem_read = 1'b1;
        mem_addr = {cpu_addr[9:2], 2'b00};
        stall    = 1'b1;
        if (cnt_q == 4'd0) begin
          fill_done = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      valid_q      <= '0;
      hit_count_q  <= 16'd0;
      miss_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fill_done) valid_q[idx] <= 1'b1;
      if (hit_inc && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
      if (miss_inc && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  // Tags and data need no reset: valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag_f;
    end else if (wr_hit) begin
      data_q[idx][{off, 5'b0} +: 32] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: one instance with FILL_CYCLES=1, one with 3,
// sharing the core-side stimulus and a word-addressed RAM model.
module tb_dcache_ctrl;

  logic         clk;
  logic         reset, reset3;
  logic [9:0]   cpu_addr;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_wdata;

  logic [31:0]  cpu_rdata, cpu_rdata3;
  logic         stall, stall3;
  logic [9:0]   mem_addr, mem_addr3;
  logic         mem_read, mem_read3;
  logic         mem_write, mem_write3;
  logic [31:0]  mem_wdata, mem_wdata3;
  logic [127:0] mem_rdata, mem_rdata3;
  logic [15:0]  hit_count, hit_count3, miss_count, miss_count3;

  logic [31:0]  ramw   [1024];
  logic [31:0]  golden [1024];
  logic [31:0]  sb [$];

  int n_vec = 0;
  int n_err = 0;
  logic sel;

  logic [31:0] s_cpu_rdata, s_mem_wdata;
  logic        s_stall, s_mem_read, s_mem_write;
  logic [9:0]  s_mem_addr;
  logic [15:0] s_hit_count, s_miss_count;

  dcache_ctrl #(.LINES(8), .FILL_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  dcache_ctrl #(.LINES(8), .FILL_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset3), .cpu_addr(cpu_addr), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata3), .stall(stall3),
    .mem_addr(mem_addr3), .mem_read(mem_read3), .mem_write(mem_write3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .hit_count(hit_count3),
    .miss_count(miss_count3)
  );

  assign mem_rdata  = {ramw[{mem_addr[9:2], 2'd3}], ramw[{mem_addr[9:2], 2'd2}],
                       ramw[{mem_addr[9:2], 2'd1}], ramw[{mem_addr[9:2], 2'd0}]};
  assign mem_rdata3 = {ramw[{mem_addr3[9:2], 2'd3}], ramw[{mem_addr3[9:2], 2'd2}],
                       ramw[{mem_addr3[9:2], 2'd1}], ramw[{mem_addr3[9:2], 2'd0}]};

  // Both instances see identical stores, so one write port covers the RAM.
  always @(posedge clk) if (mem_write) ramw[mem_addr] <= mem_wdata;

  assign s_cpu_rdata  = sel ? cpu_rdata3  : cpu_rdata;
  assign s_stall      = sel ? stall3      : stall;
  assign s_mem_addr   = sel ? mem_addr3   : mem_addr;
  assign s_mem_read   = sel ? mem_read3   : mem_read;
  assign s_mem_write  = sel ? mem_write3  : mem_write;
  assign s_mem_wdata  = sel ? mem_wdata3  : mem_wdata;
  assign s_hit_count  = sel ? hit_count3  : hit_count;
  assign s_miss_count = sel ? miss_count3 : miss_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [9:0] a, input int exp_stalls);
    int k;
    @(negedge clk);
    cpu_addr  = a;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    sb.push_back(golden[a]);
    k = 0;
    #1;
    while (s_stall && k < 40) begin
      check("fill_mem_read", s_mem_read, k > 0);
      check("fill_mem_addr", s_mem_addr, (k > 0) ? {a[9:2], 2'b00} : a);
      check("rdata_in_stall", s_cpu_rdata, 0);
      k++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", k, exp_stalls);
    check("rd_mem_read", s_mem_read, 0);
    check("rdata", s_cpu_rdata, sb.pop_front());
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic rd);
    @(negedge clk);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = 1'b1;
    cpu_read  = rd;
    #1;
    check("wr_mem_write", s_mem_write, 1);
    check("wr_mem_addr", s_mem_addr, a);
    check("wr_mem_wdata", s_mem_wdata, d);
    check("wr_stall", s_stall, 0);
    check("wr_mem_read", s_mem_read, 0);
    golden[a] = d;
  endtask

  task automatic chk_counts(input int exp_miss, input int exp_hit);
    @(negedge clk);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    #1;
    check("miss_count", s_miss_count, exp_miss);
    check("hit_count", s_hit_count, exp_hit);
    check("idle_mem_write", s_mem_write, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ramw[i] = 32'hA500_0000 | i;
    ramw[4] = 32'hA; ramw[5] = 32'hB; ramw[6] = 32'hC; ramw[7] = 32'hD;
    ramw[36] = 32'h1111; ramw[37] = 32'h2222; ramw[38] = 32'h3333; ramw[39] = 32'h4444;
    for (int i = 0; i < 1024; i++) golden[i] = ramw[i];

    sel       = 1'b0;
    reset     = 1'b1;
    reset3    = 1'b1;
    cpu_addr  = 10'h005;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", s_stall, 1);
    check("rst_hit_count", s_hit_count, 0);
    check("rst_miss_count", s_miss_count, 0);
    check("rst_mem_read", s_mem_read, 0);
    check("rst_mem_write", s_mem_write, 0);
    check("rst_rdata", s_cpu_rdata, 0);
    @(negedge clk);
    cpu_read = 1'b0;
    reset    = 1'b0;
    #1;
    check("idle_stall", s_stall, 0);

    do_read(10'h005, 2);
    chk_counts(1, 1);
    do_read(10'h006, 0);
    chk_counts(1, 2);

    // Conflict on index 1 between tag 0 and tag 1.
    do_read(10'h025, 2);
    do_read(10'h005, 2);
    chk_counts(3, 4);

    do_write(10'h005, 32'h1234, 1'b0);
    do_read(10'h005, 0);
    do_write(10'h045, 32'hBEEF, 1'b0);
    do_read(10'h005, 0);
    do_write(10'h040, 32'h55, 1'b0);
    do_read(10'h040, 2);
    chk_counts(4, 7);

    // Store with a simultaneous load: load ignored, no counting.
    do_write(10'h006, 32'h77, 1'b1);
    chk_counts(4, 7);
    do_read(10'h006, 0);

    do_read(10'h01C, 2);
    do_read(10'h01F, 0);
    chk_counts(5, 10);

    // FILL_CYCLES=3 instance.
    sel = 1'b1;
    @(negedge clk);
    reset3 = 1'b0;
    do_read(10'h005, 4);
    chk_counts(1, 1);

    @(negedge clk);
    cpu_addr = 10'h025;
    cpu_read = 1'b1;
    #1;
    check("rm_detect_stall", s_stall, 1);
    @(negedge clk);
    #1;
    check("rm_fill1_mem_read", s_mem_read, 1);
    @(negedge clk);
    #1;
    check("rm_fill2_mem_read", s_mem_read, 1);
    reset3 = 1'b1;
    #1;
    check("rm_async_mem_read", s_mem_read, 0);
    check("rm_stall", s_stall, 1);
    check("rm_miss_count", s_miss_count, 0);
    @(negedge clk);
    reset3   = 1'b0;
    cpu_read = 1'b0;
    #1;
    check("rm_idle_stall", s_stall, 0);
    do_read(10'h005, 4);
    chk_counts(1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller placed between the single-cycle core's load/store path and the 128-bit-line data RAM. It serves word reads from a local line store. On a read miss it stalls the core, fetches a full 4-word line from the RAM and installs it. Writes are forwarded to the RAM in the same cycle, and the cached copy is updated on a hit.

## Interface
Parameters:
- LINES, 8, number of cache lines; power of two, 2..64; INDEX_W = log2(LINES), TAG_W = 8 - INDEX_W
- FILL_CYCLES, 1, cycles mem_read is held before the line is captured; 1..15

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high
- cpu_addr  input  10  word address; [1:0] word offset, [INDEX_W+1:2] index, [9:INDEX_W+2] tag
- cpu_read  input  1  load request; held with a stable address while stall=1
- cpu_write  input  1  store request
- cpu_wdata  input  32  store data
- cpu_rdata  output  32  load data; valid when cpu_read=1 and stall=0
- stall  output  1  core must freeze its PC and hold its request
- mem_addr  output  10  RAM address
- mem_read  output  1  RAM line read enable
- mem_write  output  1  RAM word write enable
- mem_wdata  output  32  RAM write data
- mem_rdata  input  128  RAM line; word k occupies bits [32k+31:32k]; combinational from mem_addr while mem_read=1
- hit_count  output  16  saturating read-hit counter
- miss_count  output  16  saturating read-miss counter

## Operation
- Storage: per line one valid bit, TAG_W-bit tag, and 128-bit data. Reset clears all valid bits. Data and tags are don't-care after reset.
- hit = valid[index] and tag[index] == tag field of cpu_addr.
- FSM states:
  - IDLE:
    - cpu_write=1: mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, stall=0. On a hit, the cached word at the offset is updated on the same edge. On a miss, the cache is unchanged.
    - cpu_read=1 and cpu_write=0: on a hit, cpu_rdata is the cached word and stall=0. On a miss, stall=1 and the FSM goes to FILL with the counter loaded to FILL_CYCLES-1.
    - cpu_write has priority. A simultaneous cpu_read is ignored and no counter increments.
  - FILL: mem_read=1, mem_addr={cpu_addr[9:2],2'b00}, stall=1, mem_write=0.
    - Counter decrements each cycle.
    - On the edge where the counter is 0: data[index] <= mem_rdata, tag and valid are set, and the FSM returns to IDLE.
- In IDLE, outside the store case above, mem_read=0, mem_write=0, mem_addr=cpu_addr and mem_wdata=cpu_wdata.
- cpu_rdata = 32'h0 whenever cpu_read=0 or stall=1.
- Counters:
  - hit_count increments on each IDLE edge with cpu_read=1, cpu_write=0 and hit.
  - miss_count increments on the IDLE→FILL edge.
  - Both saturate at 16'hFFFF.
  - The re-access after a fill counts as a hit.

## Timing
- Reset values: state IDLE, all valid=0, counter=0, hit_count=0, miss_count=0, mem_read=0, mem_write=0. stall equals cpu_read & ~cpu_write (always a miss after reset).
- Read hit: 0 stall cycles; cpu_rdata is combinational in the same cycle.
- Read miss: stall=1 for exactly 1+FILL_CYCLES cycles (1 IDLE detect cycle plus FILL_CYCLES). The next cycle is a hit with stall=0.
- Store: 0 stall cycles; the RAM word and the cached word (on a hit) are written on the same edge.
- Reset asserted mid-FILL: the FSM returns to IDLE and mem_read drops asynchronously. No line is installed and all lines are invalidated.
- cpu_addr changing during FILL is a protocol violation; its behaviour is unspecified.
- Index wrap: index 0 and index LINES-1 behave identically; there is no adjacency between lines.

## Test plan
- Reset, RAM line 1 = {32'hD,32'hC,32'hB,32'hA}, read 0x005 → stall=1 for 2 cycles, mem_read=1 with mem_addr=0x004 during FILL, then cpu_rdata=32'hB with stall=0; miss_count=1, hit_count=1.
- Read 0x006 immediately after → cpu_rdata=32'hC, stall=0, mem_read stays 0; hit_count=2.
- Conflict (LINES=8): read 0x005, then read 0x025 (index 1, tag 1) → miss with refill from 0x024; re-read 0x005 → miss again; miss_count=3.
- Store hit 0x005 ← 32'h1234 → mem_write=1 with mem_addr=0x005 in the same cycle, no stall; next read of 0x005 returns 32'h1234 with no stall.
- Store miss 0x040 ← 32'h55 → RAM is written, no stall, cache unchanged; read of 0x040 then misses and returns 32'h55.
- FILL_CYCLES=3: read miss stalls exactly 4 cycles. Reset pulsed in the 2nd FILL cycle → mem_read=0 immediately, stall=cpu_read after reset, and the next read misses.
